// File: rtl/alu_branch_resolve.sv
// Pipelined branch resolution unit.
// Stage 1 evaluates the branch condition, the actual next PC and the mispredict
// flag. Any further stages only carry that result forward, so the latency equals
// STAGES. The unit also keeps saturating branch and mispredict counters that
// update when a result is handed to the consumer.
package alu_branch_pkg;
  typedef enum logic [2:0] {
    ALU_BEQ  = 3'd0,
    ALU_BNE  = 3'd1,
    ALU_BLT  = 3'd2,
    ALU_BGE  = 3'd3,
    ALU_BLTU = 3'd4,
    ALU_BGEU = 3'd5
  } alu_op_t;
endpackage

module alu_branch_resolve
  import alu_branch_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  alu_op_t              in_op,
  input  logic [WIDTH-1:0]     in_op_a,
  input  logic [WIDTH-1:0]     in_op_b,
  input  logic [WIDTH-1:0]     in_pc,
  input  logic [WIDTH-1:0]     in_imm,
  input  logic                 in_pred_taken,
  input  logic [WIDTH-1:0]     in_pred_target,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic [WIDTH-1:0]     out_next_pc,
  output logic                 out_mispredict,
  output logic                 out_invalid_op,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  // Per-stage state; index STAGES-1 drives the outputs.
  logic                 r_valid   [STAGES];
  logic                 r_taken   [STAGES];
  logic [WIDTH-1:0]     r_next_pc [STAGES];
  logic                 r_mispred [STAGES];
  logic                 r_invalid [STAGES];
  logic [TAG_WIDTH-1:0] r_tag     [STAGES];

  // Value each stage loads when the pipeline advances.
  logic                 w_s_valid   [STAGES];
  logic                 w_s_taken   [STAGES];
  logic [WIDTH-1:0]     w_s_next_pc [STAGES];
  logic                 w_s_mispred [STAGES];
  logic                 w_s_invalid [STAGES];
  logic [TAG_WIDTH-1:0] w_s_tag     [STAGES];

  logic             w_advance;
  logic             w_handshake;
  logic             w_is_branch;
  logic             w_cond;
  logic             w_taken;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_mispred;

  assign w_advance   = !r_valid[STAGES-1] || out_ready;
  assign in_ready    = w_advance;
  assign w_handshake = r_valid[STAGES-1] && out_ready;

  // Branch evaluation on the incoming request; the result enters stage 1.
  always_comb begin
    w_is_branch = 1'b1;
    w_cond      = 1'b0;
    case (in_op)
      ALU_BEQ:  w_cond = (in_op_a == in_op_b);
      ALU_BNE:  w_cond = (in_op_a != in_op_b);
      ALU_BLT:  w_cond = ($signed(in_op_a) <  $signed(in_op_b));
      ALU_BGE:  w_cond = ($signed(in_op_a) >= $signed(in_op_b));
      ALU_BLTU: w_cond = (in_op_a <  in_op_b);
      ALU_BGEU: w_cond = (in_op_a >= in_op_b);
      default:  w_is_branch = 1'b0;
    endcase
    w_taken   = w_is_branch && w_cond;
    // Both sums wrap modulo 2^WIDTH; an invalid op falls through to pc+4.
    w_next_pc = w_taken ? (in_pc + in_imm) : (in_pc + WIDTH'(4));
    // The predicted target only matters when the branch is really taken.
    w_mispred = w_is_branch &&
                ((w_taken != in_pred_taken) || (w_taken && (w_next_pc != in_pred_target)));
  end

  // Stage sources: stage 0 takes the freshly evaluated request, later stages shift.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_first
        assign w_s_valid[gi]   = in_valid && !flush;
        assign w_s_taken[gi]   = w_taken;
        assign w_s_next_pc[gi] = w_next_pc;
        assign w_s_mispred[gi] = w_mispred;
        assign w_s_invalid[gi] = !w_is_branch;
        assign w_s_tag[gi]     = in_tag;
      end else begin : g_shift
        assign w_s_valid[gi]   = r_valid[gi-1];
        assign w_s_taken[gi]   = r_taken[gi-1];
        assign w_s_next_pc[gi] = r_next_pc[gi-1];
        assign w_s_mispred[gi] = r_mispred[gi-1];
        assign w_s_invalid[gi] = r_invalid[gi-1];
        assign w_s_tag[gi]     = r_tag[gi-1];
      end
    end
  endgenerate

  // All stages move together on advance; flush kills every valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_valid[i]   <= 1'b0;
        r_taken[i]   <= 1'b0;
        r_next_pc[i] <= '0;
        r_mispred[i] <= 1'b0;
        r_invalid[i] <= 1'b0;
        r_tag[i]     <= '0;
      end
    end else begin
      if (w_advance) begin
        for (int i = 0; i < STAGES; i++) begin
          r_valid[i]   <= w_s_valid[i];
          r_taken[i]   <= w_s_taken[i];
          r_next_pc[i] <= w_s_next_pc[i];
          r_mispred[i] <= w_s_mispred[i];
          r_invalid[i] <= w_s_invalid[i];
          r_tag[i]     <= w_s_tag[i];
        end
      end
      if (flush) begin
        for (int i = 0; i < STAGES; i++) r_valid[i] <= 1'b0;
      end
    end
  end

  // Saturating performance counters, bumped on each delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (w_handshake) begin
      if (!r_invalid[STAGES-1] && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (r_mispred[STAGES-1] && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign out_valid      = r_valid[STAGES-1];
  assign out_taken      = r_taken[STAGES-1];
  assign out_next_pc    = r_next_pc[STAGES-1];
  assign out_mispredict = r_mispred[STAGES-1];
  assign out_invalid_op = r_invalid[STAGES-1];
  assign out_tag        = r_tag[STAGES-1];

endmodule

// File: doc/alu_branch_resolve.md
Name: alu_branch_resolve

Overview:
- Pipelined branch resolution unit; successor to the combinational branch comparator.
- Accepts one branch per cycle over a valid/ready handshake.
- Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU, computes the actual next PC and checks it against the front-end prediction.
- Drives a redirect on mispredict and keeps saturating branch/mispredict counters. Sits between issue and the fetch-redirect logic.

Parameters:
- WIDTH, 64, operand and PC width in bits.
- STAGES, 2, pipeline depth, legal values 1..4. Latency from input handshake to out_valid, absent stalls.
- CNT_WIDTH, 32, width of the performance counters.
- TAG_WIDTH, 6, width of the instruction tag carried alongside each branch.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  branch request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  alu_op_t  branch operation (ALU_BEQ..ALU_BGEU).
- in_op_a  input  WIDTH  rs1 value.
- in_op_b  input  WIDTH  rs2 value.
- in_pc  input  WIDTH  branch instruction PC.
- in_imm  input  WIDTH  sign-extended branch offset.
- in_pred_taken  input  1  predicted direction.
- in_pred_target  input  WIDTH  predicted next PC.
- in_tag  input  TAG_WIDTH  instruction tag.
- flush  input  1  kill all in-flight branches.
- out_valid  output  1  resolved result valid.
- out_ready  input  1  consumer accepts the result.
- out_taken  output  1  actual direction.
- out_next_pc  output  WIDTH  actual next PC.
- out_mispredict  output  1  prediction wrong; the consumer redirects to out_next_pc.
- out_invalid_op  output  1  in_op was not a branch op.
- out_tag  output  TAG_WIDTH  tag of the result.
- branch_cnt  output  CNT_WIDTH  resolved branches delivered.
- mispred_cnt  output  CNT_WIDTH  mispredicts delivered.

Behaviour:
- Reset: all stage valid bits 0. out_valid=0; out_taken, out_next_pc, out_mispredict, out_invalid_op, out_tag = 0. Both counters = 0. in_ready=1 after reset.
- Pipeline: STAGES registered stages advance together. advance = !last_stage_valid || out_ready; in_ready = advance. Input is accepted when in_valid && in_ready.
  - Bubbles are not collapsed.
  - Data registers load only on advance.
  - Outputs are held stable while out_valid && !out_ready.
- Latency: result appears exactly STAGES cycles after acceptance when out_ready stays 1. Throughput is 1 per cycle.
- Comparison is done in stage 1:
  - BEQ: a==b. BNE: a!=b.
  - BLT and BGE: signed compare. BLTU and BGEU: unsigned compare.
- Next PC:
  - taken: in_pc+in_imm. not taken: in_pc+4.
  - Both sums are modulo 2^WIDTH; wrap-around is legal and not flagged.
- Mispredict = (taken != pred_taken) || (taken && next_pc != pred_target).
  - pred_target is ignored when the branch is actually not taken.
- Invalid op: out_taken=0, out_next_pc=in_pc+4, out_invalid_op=1, out_mispredict=0.
- Counters, updated on the output handshake (out_valid && out_ready):
  - branch_cnt +1 unless out_invalid_op.
  - mispred_cnt +1 if out_mispredict.
  - Both saturate at all-ones and never wrap.
- Flush:
  - All stage valid bits clear at the next edge; out_valid=0 the following cycle.
  - A request presented in the flush cycle is dropped, even if in_ready=1.
  - A result handshaking in the flush cycle still counts.
  - Flush does not clear the counters.
- Async reset mid-operation: all in-flight work is discarded immediately and outputs return to reset values without waiting for clk.
- STAGES=1 is a single registered stage. Compare and next-PC logic for STAGES>=2 may be split across stages, provided latency equals STAGES.

Test Plan:
- STAGES=2, out_ready=1. BEQ a=5 b=5, pc=0x1000, imm=0x40, pred_taken=1, pred_target=0x1040 -> 2 cycles later out_valid=1, taken=1, next_pc=0x1040, mispredict=0, branch_cnt=1.
- BLT a=0xFFFF_FFFF_FFFF_FFFF (-1) b=1 -> taken=1; BLTU with same operands -> taken=0, next_pc=pc+4. Pred_taken=1 on the BLTU -> mispredict=1, mispred_cnt increments.
- Back-to-back 4 branches, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 while the last stage is full, no result lost or duplicated, tags emerge in order 0,1,2,3.
- Flush asserted with 2 branches in flight plus a new in_valid -> no out_valid for those 3; the next accepted branch resolves normally; counters unchanged by flush.
- Invalid op code, pred_taken=1 -> out_invalid_op=1, taken=0, mispredict=0, branch_cnt and mispred_cnt unchanged. Separately, pc=0xFFFF_FFFF_FFFF_FFFC not taken -> next_pc=0x0.
- CNT_WIDTH=4, 20 mispredicting branches -> both counters stop at 15. Assert rst mid-stream -> out_valid drops asynchronously and counters read 0.
